// File: rtl/rvfpm_result_queue_pkg.sv
// pa_rvfpm: shared types and helpers for the rvfpm result path.
// Entries are sized for the widest supported lane; narrower configurations zero-extend.
package pa_rvfpm;
    localparam int RQ_ID_MAX = 16;
    localparam int RQ_DATA_MAX = 64;

    typedef struct packed {
        logic [RQ_ID_MAX-1:0]   id;
        logic [RQ_DATA_MAX-1:0] data;
        logic [4:0]             rd;
        logic                   we;
    } rq_entry_t;

    function automatic bit is_pow2(int v);
        return v > 0 && (v & (v - 1)) == 0;
    endfunction
endpackage

// File: rtl/rvfpm_result_queue_if.sv
// rvfpm_result_queue_if: lane-side and XIF-result-side handshakes of the result queue.
interface rvfpm_result_queue_if #(
    parameter int NUM_CH = 2,
    parameter int FLEN = 32,
    parameter int X_ID_WIDTH = 4
);
    logic [NUM_CH-1:0]            ch_valid;
    logic [NUM_CH-1:0]            ch_ready;
    logic [NUM_CH*X_ID_WIDTH-1:0] ch_id;
    logic [NUM_CH*FLEN-1:0]       ch_data;
    logic [NUM_CH*5-1:0]          ch_rd;
    logic [NUM_CH-1:0]            ch_we;
    logic                         result_valid;
    logic                         result_ready;
    logic [X_ID_WIDTH-1:0]        result_id;
    logic [FLEN-1:0]              result_data;
    logic [4:0]                   result_rd;
    logic                         result_we;

    modport master (
        input  ch_valid, ch_id, ch_data, ch_rd, ch_we, result_ready,
        output ch_ready, result_valid, result_id, result_data, result_rd, result_we
    );
    modport slave (
        output ch_valid, ch_id, ch_data, ch_rd, ch_we, result_ready,
        input  ch_ready, result_valid, result_id, result_data, result_rd, result_we
    );
endinterface

// File: rtl/rvfpm_result_queue_rr_arbiter.sv
// rvfpm_rr_arbiter: one-hot round-robin grant scanning upward from ptr, plus the updated pointer.
module rvfpm_rr_arbiter #(
    parameter int N = 2,
    localparam int PW = N > 1 ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] next_ptr
);
    logic [PW-1:0] idx;

    // Scanning downward lets the closest requester above ptr win by overwriting.
    always_comb begin
        grant = '0;
        next_ptr = ptr;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr) + k) % N);
            if (req[idx]) begin
                grant = '0;
                grant[idx] = 1'b1;
                next_ptr = advance ? PW'((int'(ptr) + k + 1) % N) : ptr;
            end
        end
    end
endmodule

// File: rtl/rvfpm_result_queue.sv
// rvfpm_result_queue: round-robin admission of NUM_CH FPU lane results into a FIFO feeding the XIF result port.
// Define RVFPM_RESULT_BYPASS_EN for a zero-latency path from the granted lane when the queue is empty.
module rvfpm_result_queue
    import pa_rvfpm::*;
#(
    parameter int NUM_CH = 2,
    parameter int QUEUE_DEPTH = 4,
    parameter int FLEN = 32,
    parameter int X_ID_WIDTH = 4
) (
    input  logic                             ck,
    input  logic                             rst,
    input  logic                             enable,
    input  logic                             flush,
    rvfpm_result_queue_if.master             bus,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam int AW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;

    if (!is_pow2(QUEUE_DEPTH) || QUEUE_DEPTH < 2 || NUM_CH < 1 ||
        FLEN > RQ_DATA_MAX || X_ID_WIDTH > RQ_ID_MAX) begin : g_bad_param
        $error("rvfpm_result_queue: unsupported parameter set");
    end

    rq_entry_t             mem [QUEUE_DEPTH];
    logic [PW-1:0]         rd_ptr, wr_ptr;
    logic [AW-1:0]         rr_ptr, rr_next;
    logic [NUM_CH-1:0]     grant;
    logic                  act, pop, push, wr, byp, show;
    logic [X_ID_WIDTH-1:0] in_id;
    logic [FLEN-1:0]       in_data;
    logic [4:0]            in_rd;
    logic                  in_we;

    rvfpm_rr_arbiter #(.N(NUM_CH)) u_arb (
        .req      (bus.ch_valid),
        .ptr      (rr_ptr),
        .advance  (push),
        .grant    (grant),
        .next_ptr (rr_next)
    );

    // Reset and flush both suppress every handshake in their cycle.
    assign act  = rst && enable && !flush;
    assign show = rst && count != 0;
    assign pop  = act && count != 0 && bus.result_ready;
    assign push = act && |grant && (count < CW'(QUEUE_DEPTH) || pop);
    assign bus.ch_ready = push ? grant : '0;
`ifdef RVFPM_RESULT_BYPASS_EN
    assign byp = push && count == 0 && bus.result_ready;
`else
    assign byp = 1'b0;
`endif
    assign wr = push && !byp;

    always_comb begin
        in_id = '0;
        in_data = '0;
        in_rd = '0;
        in_we = 1'b0;
        for (int i = 0; i < NUM_CH; i++)
            if (grant[i]) begin
                in_id = bus.ch_id[i*X_ID_WIDTH +: X_ID_WIDTH];
                in_data = bus.ch_data[i*FLEN +: FLEN];
                in_rd = bus.ch_rd[i*5 +: 5];
                in_we = bus.ch_we[i];
            end
    end

    always_comb begin
        bus.result_valid = byp || (act && count != 0);
        bus.result_id = byp ? in_id : show ? X_ID_WIDTH'(mem[rd_ptr].id) : '0;
        bus.result_data = byp ? in_data : show ? FLEN'(mem[rd_ptr].data) : '0;
        bus.result_rd = byp ? in_rd : show ? mem[rd_ptr].rd : '0;
        bus.result_we = byp ? in_we : show ? mem[rd_ptr].we : 1'b0;
    end

    always_ff @(posedge ck)
        if (wr) mem[wr_ptr] <= '{id: RQ_ID_MAX'(in_id), data: RQ_DATA_MAX'(in_data), rd: in_rd, we: in_we};

    always_ff @(posedge ck) begin
        if (!rst || (enable && flush)) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            rr_ptr <= '0;
        end else if (enable) begin
            if (wr) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(wr) - CW'(pop);
            rr_ptr <= rr_next;
        end
    end
endmodule

// File: tb/tb_rvfpm_result_queue.sv
// tb_rvfpm_result_queue: directed steps; per-lane stimulus queues feed an admission-order scoreboard.
module tb_rvfpm_result_queue;
    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
    } ent_t;

    logic ck = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b1;
    logic flush = 1'b0;
    logic [2:0] count;

    rvfpm_result_queue_if #(.NUM_CH(2), .FLEN(32), .X_ID_WIDTH(4)) bus ();

    rvfpm_result_queue #(.NUM_CH(2), .QUEUE_DEPTH(4), .FLEN(32), .X_ID_WIDTH(4)) dut (
        .ck     (ck),
        .rst    (rst),
        .enable (enable),
        .flush  (flush),
        .bus    (bus.master),
        .count  (count)
    );

    always #5 ck = ~ck;

    ent_t q0[$];
    ent_t q1[$];
    ent_t sb[$];
    int checks = 0;
    int errors = 0;
    int last_grant = -1;
    int pops = 0;
    int p0;

    function automatic ent_t mk(int id, logic [31:0] data, int rd, bit we);
        ent_t e;
        e.id = 4'(id);
        e.data = data;
        e.rd = 5'(rd);
        e.we = we;
        return e;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        bus.ch_valid = {q1.size() > 0, q0.size() > 0};
        if (q0.size() > 0) begin
            bus.ch_id[3:0] = q0[0].id;
            bus.ch_data[31:0] = q0[0].data;
            bus.ch_rd[4:0] = q0[0].rd;
            bus.ch_we[0] = q0[0].we;
        end
        if (q1.size() > 0) begin
            bus.ch_id[7:4] = q1[0].id;
            bus.ch_data[63:32] = q1[0].data;
            bus.ch_rd[9:5] = q1[0].rd;
            bus.ch_we[1] = q1[0].we;
        end
    endtask

    // One clock: lane handshakes push the scoreboard, result handshakes pop and compare it.
    task automatic cyc();
        ent_t e;
        drive();
        @(negedge ck);
        last_grant = -1;
        chk("ready_onehot", 64'($countones(bus.ch_ready) <= 1), 1);
        if (bus.ch_ready[0]) begin
            chk("grant_has_req0", 64'(q0.size() > 0), 1);
            if (q0.size() > 0) sb.push_back(q0.pop_front());
            last_grant = 0;
        end
        if (bus.ch_ready[1]) begin
            chk("grant_has_req1", 64'(q1.size() > 0), 1);
            if (q1.size() > 0) sb.push_back(q1.pop_front());
            last_grant = 1;
        end
        if (bus.result_valid && bus.result_ready) begin
            pops++;
            if (sb.size() == 0) chk("pop_unexpected", 64'(1), 0);
            else begin
                e = sb.pop_front();
                chk("res_id", 64'(bus.result_id), 64'(e.id));
                chk("res_data", 64'(bus.result_data), 64'(e.data));
                chk("res_rd", 64'(bus.result_rd), 64'(e.rd));
                chk("res_we", 64'(bus.result_we), 64'(e.we));
            end
        end
        @(posedge ck);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ch_valid = '0;
        bus.ch_id = '0;
        bus.ch_data = '0;
        bus.ch_rd = '0;
        bus.ch_we = '0;
        bus.result_ready = 1'b0;
        // Reset with both lanes requesting.
        q0.push_back(mk(0, 32'h1111_0000, 1, 1));
        q0.push_back(mk(2, 32'h1111_0002, 2, 0));
        q1.push_back(mk(1, 32'h2222_0001, 3, 1));
        q1.push_back(mk(3, 32'h2222_0003, 4, 1));
        drive();
        repeat (2) @(posedge ck);
        #1;
        chk("rst_ready", 64'(bus.ch_ready), 0);
        chk("rst_valid", 64'(bus.result_valid), 0);
        chk("rst_count", 64'(count), 0);
        chk("rst_id", 64'(bus.result_id), 0);
        // Fairness and one-cycle latency.
        rst = 1'b1;
        bus.result_ready = 1'b1;
        cyc();
        chk("grant_first", 64'(last_grant), 0);
        chk("lat_valid", 64'(bus.result_valid), 1);
        chk("lat_id", 64'(bus.result_id), 0);
        cyc();
        chk("grant_second", 64'(last_grant), 1);
        cyc();
        chk("grant_third", 64'(last_grant), 0);
        cyc();
        chk("grant_fourth", 64'(last_grant), 1);
        repeat (2) cyc();
        chk("fair_drain_count", 64'(count), 0);
        chk("fair_sb_empty", 64'(sb.size()), 0);
        chk("empty_data_zero", 64'(bus.result_data), 0);
        chk("empty_valid", 64'(bus.result_valid), 0);
        // Fill to full under backpressure, then pop and push in one cycle.
        bus.result_ready = 1'b0;
        for (int i = 1; i <= 5; i++) q0.push_back(mk(i, 32'hA000 + 32'(i), i, 1));
        repeat (4) cyc();
        chk("fill_count", 64'(count), 4);
        drive();
        #1;
        chk("full_ready", 64'(bus.ch_ready), 0);
        chk("full_head_id", 64'(bus.result_id), 1);
        bus.result_ready = 1'b1;
        cyc();
        chk("swap_grant", 64'(last_grant), 0);
        chk("swap_count", 64'(count), 4);
        repeat (4) cyc();
        chk("fill_drain_count", 64'(count), 0);
        chk("fill_lane_empty", 64'(q0.size()), 0);
        // Wrap-around with random result stalls.
        p0 = pops;
        for (int i = 0; i < 10; i++) q1.push_back(mk(i, $urandom, i + 8, i[0]));
        for (int n = 0; n < 300 && (q1.size() > 0 || sb.size() > 0); n++) begin
            bus.result_ready = 1'($urandom_range(0, 1));
            cyc();
            chk("wrap_count_max", 64'(count <= 4), 1);
        end
        chk("wrap_done", 64'(q1.size() + sb.size()), 0);
        chk("wrap_pops", 64'(pops - p0), 10);
        // Flush with lanes requesting.
        bus.result_ready = 1'b0;
        for (int i = 10; i < 13; i++) q0.push_back(mk(i, 32'hF000 + 32'(i), i, 0));
        repeat (3) cyc();
        chk("flush_pre_count", 64'(count), 3);
        q0.push_back(mk(13, 32'hF00D, 13, 1));
        q1.push_back(mk(14, 32'hF00E, 14, 1));
        flush = 1'b1;
        drive();
        #1;
        chk("flush_ready", 64'(bus.ch_ready), 0);
        cyc();
        flush = 1'b0;
        sb.delete();
        chk("flush_count", 64'(count), 0);
        chk("flush_valid", 64'(bus.result_valid), 0);
        cyc();
        chk("flush_rr", 64'(last_grant), 0);
        bus.result_ready = 1'b1;
        repeat (4) cyc();
        chk("flush_drain_count", 64'(count), 0);
        chk("flush_sb_empty", 64'(sb.size()), 0);
        // Enable low holds everything.
        bus.result_ready = 1'b0;
        q0.push_back(mk(4, 32'hE004, 20, 1));
        q0.push_back(mk(5, 32'hE005, 21, 0));
        repeat (2) cyc();
        chk("en_pre_count", 64'(count), 2);
        q0.push_back(mk(6, 32'hE006, 22, 1));
        enable = 1'b0;
        bus.result_ready = 1'b1;
        repeat (3) begin
            cyc();
            chk("en_valid", 64'(bus.result_valid), 0);
            chk("en_count", 64'(count), 2);
            chk("en_grant", 64'(last_grant), -1);
        end
        enable = 1'b1;
        drive();
        #1;
        chk("en_resume_valid", 64'(bus.result_valid), 1);
        chk("en_resume_id", 64'(bus.result_id), 4);
        repeat (4) cyc();
        chk("en_drain_count", 64'(count), 0);
        chk("en_sb_empty", 64'(sb.size()), 0);
        // Empty queue, lane 1 offers id 7 with result_ready high.
        bus.result_ready = 1'b1;
        q1.push_back(mk(7, 32'hBEEF_0007, 7, 1));
        drive();
        #1;
`ifdef RVFPM_RESULT_BYPASS_EN
        chk("byp_valid", 64'(bus.result_valid), 1);
        chk("byp_id", 64'(bus.result_id), 7);
        cyc();
        chk("byp_count", 64'(count), 0);
`else
        chk("nobyp_valid", 64'(bus.result_valid), 0);
        cyc();
        chk("nobyp_count", 64'(count), 1);
        chk("nobyp_valid_next", 64'(bus.result_valid), 1);
        cyc();
        chk("nobyp_drain_count", 64'(count), 0);
`endif
        chk("final_sb_empty", 64'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
